// File: rtl/tenyr_data_responder.sv
// rtl/tenyr_data_responder.sv - data-bus RAM window responder with strobe/ready handshake
// Optional parity storage and check: define TENYR_RESPONDER_PARITY_EN.
module tenyr_data_responder #(
    parameter int          ADDR_BITS    = 10,
    parameter logic [31:0] BASE         = 32'h1000,
    parameter int          READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        strobe,
    input  logic        mem_rw,
    input  logic [31:0] d_addr,
    inout  wire  [31:0] d_data,
    output logic        ready,
    output logic        fault
);

`ifdef TENYR_RESPONDER_PARITY_EN
    localparam int RAM_W = 33;
`else
    localparam int RAM_W = 32;
`endif
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RWAIT,
        S_DRIVE,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] idx_q, idx_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 fault_q, fault_d;
    logic                 ready_q, ready_d;

    logic [RAM_W-1:0]     mem_q [0:DEPTH-1];
    logic [RAM_W-1:0]     mem_rd;
    logic [RAM_W-1:0]     mem_wr_word;
    logic                 mem_we;
    logic                 par_err;
    logic                 hit;
    logic                 drive_en;

    assign hit    = (d_addr >> ADDR_BITS) == (BASE >> ADDR_BITS);
    assign mem_rd = mem_q[idx_q];

`ifdef TENYR_RESPONDER_PARITY_EN
    // Bit 32 holds even parity, so a healthy word always XORs to zero.
    assign mem_wr_word = {^wdata_q, wdata_q};
    assign par_err     = ^mem_rd;
`else
    assign mem_wr_word = wdata_q;
    assign par_err     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        mem_we  = 1'b0;
        if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (strobe) begin
                        if (!hit) begin
                            state_d = S_DONE;
                            fault_d = 1'b1;
                            rdata_d = '0;
                        end else if (mem_rw) begin
                            state_d = S_WRITE;
                            idx_d   = d_addr[ADDR_BITS-1:0];
                            wdata_d = d_data;
                        end else begin
                            state_d = S_RWAIT;
                            idx_d   = d_addr[ADDR_BITS-1:0];
                            cnt_d   = 2'(READ_LATENCY - 1);
                        end
                    end
                end
                S_WRITE: begin
                    // A strobe withdrawn before commit drops the write entirely.
                    if (!strobe) begin
                        state_d = S_IDLE;
                    end else begin
                        mem_we  = 1'b1;
                        state_d = S_DONE;
                    end
                end
                S_RWAIT: begin
                    if (!strobe) begin
                        state_d = S_IDLE;
                    end else if (cnt_q == 2'd0) begin
                        state_d = S_DRIVE;
                        rdata_d = mem_rd[31:0];
                        if (par_err) begin
                            fault_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                S_DRIVE: state_d = strobe ? S_DONE : S_IDLE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        ready_d = (state_d == S_DONE);
    end

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            ready_q <= ready_d;
        end
    end

    // RAM survives reset; the WRITE state is left by reset, which gates mem_we.
    always_ff @(negedge clk) begin
        if (mem_we) begin
            mem_q[idx_q] <= mem_wr_word;
        end
    end

    assign drive_en = en & strobe & ~mem_rw & ((state_q == S_DRIVE) | (state_q == S_DONE));
    assign d_data   = drive_en ? rdata_q : 32'bz;
    assign ready    = ready_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_tenyr_data_responder.sv
// tb/tb_tenyr_data_responder.sv - randomized self-checking bench, four latency variants
module tb_tenyr_data_responder;

    localparam logic [31:0] BASE = 32'h1000;
    localparam int          AB   = 10;
    localparam logic [31:0] ZVAL = 32'hFFFF_FFFF;

    logic        clk;
    logic        reset_n;
    logic        en;
    logic        strobe;
    logic        mem_rw;
    logic [31:0] d_addr;
    logic        tb_oe;
    logic [31:0] tb_wdata;
    logic [31:0] obs [4];
    logic        rdy [4];
    logic        flt [4];

    int checks = 0;
    int errors = 0;

    logic [31:0] model [1024];

    for (genvar g = 0; g < 4; g++) begin : gen_inst
        wire [31:0] bus;
        wire        rdy_w;
        wire        flt_w;
        pullup pu (bus);
        assign bus = tb_oe ? tb_wdata : 32'bz;
        tenyr_data_responder #(
            .ADDR_BITS   (AB),
            .BASE        (BASE),
            .READ_LATENCY(g + 1)
        ) u_dut (
            .clk    (clk),
            .reset_n(reset_n),
            .en     (en),
            .strobe (strobe),
            .mem_rw (mem_rw),
            .d_addr (d_addr),
            .d_data (bus),
            .ready  (rdy_w),
            .fault  (flt_w)
        );
        assign obs[g] = bus;
        assign rdy[g] = rdy_w;
        assign flt[g] = flt_w;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Stimulus only: returns ready latency (in negedges) and data seen on the READ_LATENCY=2 instance.
    task automatic do_read(input logic [31:0] addr, output int lat, output logic [31:0] data);
        lat      = -1;
        data     = 32'h0;
        strobe   = 1'b1;
        mem_rw   = 1'b0;
        d_addr   = addr;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (rdy[1]) begin
                lat  = n;
                data = obs[1];
                break;
            end
        end
        strobe = 1'b0;
        tick();
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            output int lat, output bit clash);
        lat      = -1;
        clash    = 1'b0;
        strobe   = 1'b1;
        mem_rw   = 1'b1;
        d_addr   = addr;
        tb_oe    = 1'b1;
        tb_wdata = data;
        for (int n = 1; n <= 20; n++) begin
            tick();
            for (int g = 0; g < 4; g++) if (obs[g] !== data) clash = 1'b1;
            if (rdy[1]) begin
                lat = n;
                break;
            end
        end
        strobe = 1'b0;
        tb_oe  = 1'b0;
        mem_rw = 1'b0;
        tick();
    endtask

    function automatic logic [31:0] rand_word();
        return $urandom() & 32'h7FFF_FFFE;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (rdy[g] !== 1'b0) begin errors++; $display("FAIL reset_ready[%0d] got=%b exp=0", g, rdy[g]); end
            checks++;
            if (flt[g] !== 1'b0) begin errors++; $display("FAIL reset_fault[%0d] got=%b exp=0", g, flt[g]); end
            checks++;
            if (obs[g] !== ZVAL) begin errors++; $display("FAIL reset_ddata_z[%0d] got=%h exp=%h", g, obs[g], ZVAL); end
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        int lat;
        bit clash;
        logic [31:0] data;
        do_write(BASE + 5, 32'hDEAD_BEEF, lat, clash);
        model[5] = 32'hDEAD_BEEF;
        checks++;
        if (lat != 2) begin errors++; $display("FAIL wr_latency got=%0d exp=2", lat); end
        checks++;
        if (clash) begin errors++; $display("FAIL wr_ddata_driven got=1 exp=0"); end
        do_read(BASE + 5, lat, data);
        checks++;
        if (lat != 4) begin errors++; $display("FAIL rd_latency got=%0d exp=4", lat); end
        checks++;
        if (data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data got=%h exp=deadbeef", data); end
        checks++;
        if (flt[1] !== 1'b0) begin errors++; $display("FAIL rd_fault got=%b exp=0", flt[1]); end
        checks++;
        if (obs[1] !== ZVAL) begin errors++; $display("FAIL rd_release got=%h exp=%h", obs[1], ZVAL); end
    endtask

    task automatic test_random();
        int idx [8];
        int lat;
        bit clash;
        logic [31:0] data;
        logic [31:0] w;
        for (int i = 0; i < 8; i++) begin
            idx[i] = (i == 0) ? 0 : ((i == 7) ? 1023 : int'($urandom_range(8, 1022)));
            w = rand_word();
            do_write(BASE + 32'(idx[i]), w, lat, clash);
            model[idx[i]] = w;
            checks++;
            if (lat != 2 || clash) begin
                errors++;
                $display("FAIL rand_write[%0d] lat=%0d clash=%0b exp lat=2 clash=0", i, lat, clash);
            end
        end
        for (int i = 7; i >= 0; i--) begin
            do_read(BASE + 32'(idx[i]), lat, data);
            checks++;
            if (lat != 4 || data !== model[idx[i]]) begin
                errors++;
                $display("FAIL rand_read[%0d] lat=%0d data=%h exp lat=4 data=%h", i, lat, data, model[idx[i]]);
            end
        end
    endtask

    task automatic test_latency_en();
        int first [4];
        logic [31:0] seen [4];
        for (int g = 0; g < 4; g++) first[g] = -1;
        strobe = 1'b1;
        mem_rw = 1'b0;
        d_addr = BASE + 5;
        for (int n = 1; n <= 15; n++) begin
            tick();
            en = (n >= 1 && n <= 3) ? 1'b0 : 1'b1;
            for (int g = 0; g < 4; g++) begin
                if (rdy[g] && first[g] < 0) begin
                    first[g] = n;
                    seen[g]  = obs[g];
                end
            end
            if (first[3] >= 0) break;
        end
        en     = 1'b1;
        strobe = 1'b0;
        tick();
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (first[g] != g + 1 + 2 + 3) begin
                errors++;
                $display("FAIL en_latency[L=%0d] got=%0d exp=%0d", g + 1, first[g], g + 6);
            end
            checks++;
            if (first[g] >= 0 && seen[g] !== model[5]) begin
                errors++;
                $display("FAIL en_data[L=%0d] got=%h exp=%h", g + 1, seen[g], model[5]);
            end
        end
    endtask

    task automatic test_abort_write();
        int lat;
        int readies;
        bit clash;
        logic [31:0] data;
        logic [31:0] prior;
        prior = rand_word();
        do_write(BASE + 7, prior, lat, clash);
        model[7] = prior;
        strobe   = 1'b1;
        mem_rw   = 1'b1;
        d_addr   = BASE + 7;
        tb_oe    = 1'b1;
        tb_wdata = 32'h1;
        tick();
        strobe  = 1'b0;
        tb_oe   = 1'b0;
        mem_rw  = 1'b0;
        readies = 0;
        repeat (3) begin
            tick();
            if (rdy[1]) readies++;
        end
        checks++;
        if (readies != 0) begin errors++; $display("FAIL abort_ready got=%0d exp=0", readies); end
        do_read(BASE + 7, lat, data);
        checks++;
        if (data !== prior) begin errors++; $display("FAIL abort_data got=%h exp=%h", data, prior); end
    endtask

    task automatic test_parity();
        int lat;
        bit clash;
        logic exp_fault;
        logic [31:0] data;
        logic [31:0] w;
        w = rand_word();
        do_write(BASE + 3, w, lat, clash);
        model[3] = w;
`ifdef TENYR_RESPONDER_PARITY_EN
        gen_inst[1].u_dut.mem_q[3][32] = ~gen_inst[1].u_dut.mem_q[3][32];
        exp_fault = 1'b1;
`else
        exp_fault = 1'b0;
`endif
        do_read(BASE + 3, lat, data);
        checks++;
        if (data !== w) begin errors++; $display("FAIL parity_data got=%h exp=%h", data, w); end
        checks++;
        if (flt[1] !== exp_fault) begin errors++; $display("FAIL parity_fault got=%b exp=%b", flt[1], exp_fault); end
    endtask

    task automatic test_out_of_window();
        int lat;
        logic [31:0] data;
        do_read(BASE + 32'(1 << AB), lat, data);
        checks++;
        if (lat != 1) begin errors++; $display("FAIL oow_latency got=%0d exp=1", lat); end
        checks++;
        if (data !== 32'h0) begin errors++; $display("FAIL oow_data got=%h exp=0", data); end
        checks++;
        if (flt[1] !== 1'b1) begin errors++; $display("FAIL oow_fault got=%b exp=1", flt[1]); end
        do_read(BASE, lat, data);
        checks++;
        if (lat != 4 || data !== model[0]) begin
            errors++;
            $display("FAIL oow_next_read lat=%0d data=%h exp lat=4 data=%h", lat, data, model[0]);
        end
        checks++;
        if (flt[1] !== 1'b1) begin errors++; $display("FAIL oow_fault_sticky got=%b exp=1", flt[1]); end
    endtask

    task automatic test_reset_mid_read();
        int lat;
        logic [31:0] data;
        strobe = 1'b1;
        mem_rw = 1'b0;
        d_addr = BASE + 5;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (rdy[1] !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%b exp=0", rdy[1]); end
        checks++;
        if (obs[1] !== ZVAL) begin errors++; $display("FAIL midrst_ddata got=%h exp=%h", obs[1], ZVAL); end
        checks++;
        if (flt[1] !== 1'b0) begin errors++; $display("FAIL midrst_fault got=%b exp=0", flt[1]); end
        strobe = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        do_read(BASE + 5, lat, data);
        checks++;
        if (lat != 4 || data !== model[5]) begin
            errors++;
            $display("FAIL midrst_retained lat=%0d data=%h exp lat=4 data=%h", lat, data, model[5]);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        en       = 1'b1;
        strobe   = 1'b0;
        mem_rw   = 1'b0;
        d_addr   = 32'h0;
        tb_oe    = 1'b0;
        tb_wdata = 32'h0;
        for (int i = 0; i < 1024; i++) model[i] = 32'h0;
        test_reset();
        test_write_read();
        test_random();
        test_latency_en();
        test_abort_write();
        test_parity();
        test_out_of_window();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
